// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter in front of the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin instead of fixed priority with port-1 starvation guard.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req0_valid_in,
  output logic                  req0_ready_out,
  input  logic                  req0_we_in,
  input  logic                  req0_mode_in,
  input  logic [ADDR_WIDTH-1:0] req0_addr_in,
  input  logic [DATA_WIDTH-1:0] req0_wdata_in,
  output logic                  rsp0_valid_out,
  output logic [DATA_WIDTH-1:0] rsp0_rdata_out,
  input  logic                  req1_valid_in,
  output logic                  req1_ready_out,
  input  logic                  req1_we_in,
  input  logic                  req1_mode_in,
  input  logic [ADDR_WIDTH-1:0] req1_addr_in,
  input  logic [DATA_WIDTH-1:0] req1_wdata_in,
  output logic                  rsp1_valid_out,
  output logic [DATA_WIDTH-1:0] rsp1_rdata_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_we_out,
  output logic                  mem_mode_out,
  output logic [DATA_WIDTH-1:0] mem_wd_out,
  input  logic [DATA_WIDTH-1:0] mem_rd_in
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic port_q, we_q, mode_q, gnt0, gnt1, idle, access;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd0_q, rd1_q;
`ifdef DMEM_ARB_RR_EN
  logic ptr;
  assign gnt0 = req0_valid_in && (!req1_valid_in || !ptr);
`else
  logic [3:0] wait1;
  assign gnt0 = req0_valid_in && !(req1_valid_in && wait1 == 4'(MAX_WAIT));
`endif
  assign gnt1 = req1_valid_in && !gnt0;
  assign idle = state == IDLE;
  assign access = state == ACCESS;
  assign req0_ready_out = idle && gnt0;
  assign req1_ready_out = idle && gnt1;
  assign rsp0_valid_out = state == RESP && !port_q;
  assign rsp1_valid_out = state == RESP && port_q;
  assign rsp0_rdata_out = rd0_q;
  assign rsp1_rdata_out = rd1_q;
  assign mem_a_out = access ? addr_q : '0;
  assign mem_we_out = access && we_q;
  assign mem_mode_out = access && mode_q;
  assign mem_wd_out = access ? wdata_q : '0;
  always_comb begin
    state_nx = IDLE;
    state_nx = idle ? ((gnt0 || gnt1) ? ACCESS : IDLE) : access ? RESP : IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      port_q <= 1'b0;
      we_q <= 1'b0;
      mode_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr <= 1'b0;
`else
      wait1 <= 4'd0;
`endif
    end else begin
      state <= state_nx;
      if (idle && (gnt0 || gnt1)) begin
        port_q <= gnt1;
        we_q <= gnt1 ? req1_we_in : req0_we_in;
        mode_q <= gnt1 ? req1_mode_in : req0_mode_in;
        addr_q <= gnt1 ? req1_addr_in : req0_addr_in;
        wdata_q <= gnt1 ? req1_wdata_in : req0_wdata_in;
      end
      // writes return zero so the response doubles as a write acknowledge
      if (access && !port_q) rd0_q <= we_q ? '0 : mem_rd_in;
      if (access && port_q) rd1_q <= we_q ? '0 : mem_rd_in;
`ifdef DMEM_ARB_RR_EN
      if (req0_ready_out || req1_ready_out) ptr <= req0_ready_out;
`else
      if (req1_ready_out) wait1 <= 4'd0;
      else if (req0_ready_out && req1_valid_in && wait1 != 4'(MAX_WAIT)) wait1 <= wait1 + 4'd1;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of handshake, memory sequencing, reset drop and arbitration order.
module tb_dmem_arbiter;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic req0_valid_in = 0, req0_ready_out, req0_we_in = 0, req0_mode_in = 0;
  logic req1_valid_in = 0, req1_ready_out, req1_we_in = 0, req1_mode_in = 0;
  logic [31:0] req0_addr_in = 0, req0_wdata_in = 0, req1_addr_in = 0, req1_wdata_in = 0;
  logic rsp0_valid_out, rsp1_valid_out, mem_we_out, mem_mode_out;
  logic [31:0] rsp0_rdata_out, rsp1_rdata_out, mem_a_out, mem_wd_out, mem_rd_in;
  logic [31:0] mem [0:255];
  int total = 0, bad = 0, cyc = 0, rsp1_cnt = 0, a1_cnt = 0, gn = 0;
  int g [0:15];
  int gc [0:15];

  always #5 clk_in = ~clk_in;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out), .req0_we_in(req0_we_in),
    .req0_mode_in(req0_mode_in), .req0_addr_in(req0_addr_in), .req0_wdata_in(req0_wdata_in),
    .rsp0_valid_out(rsp0_valid_out), .rsp0_rdata_out(rsp0_rdata_out),
    .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out), .req1_we_in(req1_we_in),
    .req1_mode_in(req1_mode_in), .req1_addr_in(req1_addr_in), .req1_wdata_in(req1_wdata_in),
    .rsp1_valid_out(rsp1_valid_out), .rsp1_rdata_out(rsp1_rdata_out),
    .mem_a_out(mem_a_out), .mem_we_out(mem_we_out), .mem_mode_out(mem_mode_out),
    .mem_wd_out(mem_wd_out), .mem_rd_in(mem_rd_in)
  );

  initial mem[3] = 32'h0000_00A5;
  always @(posedge clk_in) if (mem_we_out) mem[mem_a_out[7:0]] <= mem_wd_out;
  assign mem_rd_in = mem[mem_a_out[7:0]];

  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    if (rsp1_valid_out) rsp1_cnt++;
    if (mem_a_out == 32'h50) a1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic drive(input logic p, input logic v, input logic we, input logic mode,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      req1_valid_in = v; req1_we_in = we; req1_mode_in = mode; req1_addr_in = a; req1_wdata_in = d;
    end else begin
      req0_valid_in = v; req0_we_in = we; req0_mode_in = mode; req0_addr_in = a; req0_wdata_in = d;
    end
  endtask

  // single transaction on one port, checked cycle by cycle
  task automatic do_req(input logic p, input logic we, input logic mode,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    int n = 0;
    tick();
    drive(p, 1'b1, we, mode, a, d);
    #1;
    while (!(p ? req1_ready_out : req0_ready_out) && n < 20) begin
      tick();
      n++;
    end
    chk("ready_timeout", n < 20, 1);
    tick();
    drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("acc_we", mem_we_out, we);
    chk("acc_addr", mem_a_out, a);
    chk("acc_mode", mem_mode_out, mode);
    chk("acc_wd", mem_wd_out, d);
    tick();
    chk("rsp_own", p ? rsp1_valid_out : rsp0_valid_out, 1);
    chk("rsp_other", p ? rsp0_valid_out : rsp1_valid_out, 0);
    chk("rsp_we_off", mem_we_out, 0);
    chk("rsp_rdata", p ? rsp1_rdata_out : rsp0_rdata_out, we ? 32'h0 : exp_rd);
    tick();
    chk("rsp_once", rsp0_valid_out | rsp1_valid_out, 0);
  endtask

  // records the next n grants; called at negedge+1 with valids already driven
  task automatic collect(input int n);
    gn = 0;
    for (int c = 0; c < 200 && gn < n; c++) begin
      chk("one_ready", req0_ready_out & req1_ready_out, 0);
      if (req0_ready_out || req1_ready_out) begin
        g[gn] = req1_ready_out ? 1 : 0;
        gc[gn] = cyc;
        gn++;
      end
      if (gn < n) tick();
    end
    chk("grant_timeout", gn, n);
  endtask

  initial begin
    int exp_seq [0:9];
    int r1, a1;
    tick();
    tick();
    chk("rst_ready0", req0_ready_out, 0);
    chk("rst_rsp", rsp0_valid_out | rsp1_valid_out, 0);
    chk("rst_mem_a", mem_a_out, 0);
    chk("rst_rdata0", rsp0_rdata_out, 0);
    rst_in = 1'b1;
    // reset while a read of 0x10 is in ACCESS
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    chk("inflight_ready", req0_ready_out, 1);
    tick();
    chk("inflight_addr", mem_a_out, 32'h10);
    rst_in = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("drop_rsp0", rsp0_valid_out, 0);
    chk("drop_mem_a", mem_a_out, 0);
    chk("drop_we", mem_we_out, 0);
    rst_in = 1'b1;
    tick();
    chk("drop_rsp0_late", rsp0_valid_out, 0);
    do_req(1'b0, 1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0);
    do_req(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 1'b1, 32'h3, 32'h0, 32'h0000_00A5);
    chk("rdata0_hold", rsp0_rdata_out, 32'hDEADBEEF);
    // both ports valid continuously
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    #1;
    collect(10);
`ifdef DMEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    for (int i = 0; i < 10; i++) chk($sformatf("grant%0d", i), g[i], exp_seq[i]);
    tick();
    req1_valid_in = 1'b0;
    #1;
    collect(4);
    for (int i = 0; i < 4; i++) chk($sformatf("solo_port%0d", i), g[i], 0);
    for (int i = 1; i < 4; i++) chk($sformatf("solo_gap%0d", i), gc[i] - gc[i-1], 3);
    tick();
    req0_valid_in = 1'b0;
`ifndef DMEM_ARB_RR_EN
    // port 1 withdraws after losing twice; its wait count must survive
    tick();
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    #1;
    collect(2);
    chk("pre_drop", g[0] + g[1], 0);
    tick();
    req1_valid_in = 1'b0;
    r1 = rsp1_cnt;
    a1 = a1_cnt;
    #1;
    collect(2);
    chk("drop_grants", g[0] + g[1], 0);
    tick();
    tick();
    chk("drop_no_rsp1", rsp1_cnt - r1, 0);
    chk("drop_no_access", a1_cnt - a1, 0);
    req1_valid_in = 1'b1;
    #1;
    collect(3);
    chk("resume0", g[0], 0);
    chk("resume1", g[1], 0);
    chk("resume2", g[2], 1);
    tick();
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
`endif
    tick();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
